// File: rtl/pixel_seq_pkg.sv
// Shared definitions for the pixel frame sequencer: FSM state encoding,
// frame counter width and default geometry.
package pixel_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PUSH  = 3'd3,
        ST_LATCH = 3'd4
    } seq_state_e;

    localparam int FRAME_CNT_W   = 16;
    localparam int DEF_LED_COUNT = 298;
    localparam int DEF_CHANNELS  = 1;
    localparam int DEF_IDX_W     = 10;
    localparam int DEF_CH_W      = 3;

endpackage

// File: rtl/pixel_sequencer_if.sv
// Handshake bundle between the sequencer (master), the pixel renderer and
// the pixel_driver strips (slave side is renderer + drivers).
interface pixel_sequencer_if #(
    parameter int IDX_W    = 10,
    parameter int CH_W     = 3,
    parameter int CHANNELS = 1
) ();
    // Request channel towards the renderer
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_index;
    logic [CH_W-1:0]  req_channel;
    logic             req_tick;
    // Colour response from the renderer
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_red;
    logic [7:0]       rsp_green;
    logic [7:0]       rsp_blue;
    // Shared colour bus and per-strip handshakes towards the drivers
    logic [CHANNELS-1:0] out_valid;
    logic [CHANNELS-1:0] out_ready;
    logic                out_reset;
    logic [7:0]          out_red;
    logic [7:0]          out_green;
    logic [7:0]          out_blue;

    modport master (
        output req_valid, req_index, req_channel, req_tick,
        input  req_ready,
        input  rsp_valid, rsp_red, rsp_green, rsp_blue,
        output rsp_ready,
        output out_valid, out_reset, out_red, out_green, out_blue,
        input  out_ready
    );

    modport slave (
        input  req_valid, req_index, req_channel, req_tick,
        output req_ready,
        output rsp_valid, rsp_red, rsp_green, rsp_blue,
        input  rsp_ready,
        input  out_valid, out_reset, out_red, out_green, out_blue,
        output out_ready
    );
endinterface

// File: rtl/rgb_scale.sv
// Combinational brightness scaler: each component becomes (c*(scale+1))>>8,
// so scale=255 passes colour through and scale=0 yields black.
// Only compiled in the PIXEL_SEQUENCER_BRIGHTNESS_EN build, the only build
// that instantiates it.
`ifdef PIXEL_SEQUENCER_BRIGHTNESS_EN
module rgb_scale (
    input  logic [7:0] scale_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o
);
    // 8x9 product always fits 17 bits; the shifted result never exceeds 255
    function automatic logic [7:0] scale_comp(input logic [7:0] c, input logic [7:0] s);
        logic [16:0] prod;
        prod = {9'd0, c} * ({9'd0, s} + 17'd1);
        return 8'(prod >> 8);
    endfunction

    assign red_o   = scale_comp(red_i,   scale_i);
    assign green_o = scale_comp(green_i, scale_i);
    assign blue_o  = scale_comp(blue_i,  scale_i);
endmodule
`endif

// File: rtl/pixel_sequencer.sv
// Frame sequencer: walks every (index, channel) pixel in pixel-major order,
// fetches its colour from the renderer and hands it to the matching driver,
// then latches all strips and pulses frame_tick.
// Optional build macro PIXEL_SEQUENCER_BRIGHTNESS_EN adds a brightness input
// that scales the captured colour.
module pixel_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int LED_COUNT = DEF_LED_COUNT,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int CH_W      = DEF_CH_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
`ifdef PIXEL_SEQUENCER_BRIGHTNESS_EN
    input  logic [7:0]             brightness,
`endif
    pixel_sequencer_if.master      bus,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count
);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(LED_COUNT - 1);
    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] ALL_CH   = {CHANNELS{1'b1}};

    seq_state_e               state_q;
    logic [IDX_W-1:0]         index_q, index_d;
    logic [CH_W-1:0]          channel_q, channel_d;
    logic                     frame_done_d;
    logic                     req_valid_q, req_tick_q, rsp_ready_q;
    logic [CHANNELS-1:0]      out_valid_q;
    logic                     out_reset_q, frame_tick_q;
    logic [FRAME_CNT_W-1:0]   frame_count_q;
    logic [7:0]               red_q, green_q, blue_q;
    logic [7:0]               cap_red, cap_green, cap_blue;

`ifdef PIXEL_SEQUENCER_BRIGHTNESS_EN
    rgb_scale u_scale (
        .scale_i (brightness),
        .red_i   (bus.rsp_red),
        .green_i (bus.rsp_green),
        .blue_i  (bus.rsp_blue),
        .red_o   (cap_red),
        .green_o (cap_green),
        .blue_o  (cap_blue)
    );
`else
    assign cap_red   = bus.rsp_red;
    assign cap_green = bus.rsp_green;
    assign cap_blue  = bus.rsp_blue;
`endif

    // Next pixel position after a push: channel-minor, then index; flags the last pixel
    always_comb begin
        index_d      = index_q;
        channel_d    = channel_q;
        frame_done_d = 1'b0;
        if (channel_q != LAST_CH) begin
            channel_d = channel_q + CH_W'(1);
        end else if (index_q != LAST_IDX) begin
            channel_d = '0;
            index_d   = index_q + IDX_W'(1);
        end else begin
            frame_done_d = 1'b1;
        end
    end

    // Sequencer FSM; every output is a register updated on the state transition
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            channel_q     <= '0;
            req_valid_q   <= 1'b0;
            req_tick_q    <= 1'b0;
            rsp_ready_q   <= 1'b0;
            out_valid_q   <= '0;
            out_reset_q   <= 1'b0;
            frame_tick_q  <= 1'b0;
            frame_count_q <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            frame_tick_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    index_q   <= '0;
                    channel_q <= '0;
                    if (enable) begin
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                        req_tick_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.req_ready) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                        req_tick_q  <= 1'b0;
                        rsp_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.rsp_valid) begin
                        state_q     <= ST_PUSH;
                        rsp_ready_q <= 1'b0;
                        red_q       <= cap_red;
                        green_q     <= cap_green;
                        blue_q      <= cap_blue;
                        out_valid_q <= CHANNELS'(1) << channel_q;
                    end
                end
                ST_PUSH: begin
                    // out_valid_q is one-hot on the current channel here
                    if ((bus.out_ready & out_valid_q) != '0) begin
                        index_q   <= index_d;
                        channel_q <= channel_d;
                        if (frame_done_d) begin
                            state_q     <= ST_LATCH;
                            out_reset_q <= 1'b1;
                            out_valid_q <= ALL_CH;
                        end else begin
                            state_q     <= ST_REQ;
                            out_valid_q <= '0;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    if (&bus.out_ready) begin
                        out_reset_q   <= 1'b0;
                        out_valid_q   <= '0;
                        frame_tick_q  <= 1'b1;
                        frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
                        index_q       <= '0;
                        channel_q     <= '0;
                        if (enable) begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                            req_tick_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_valid   = req_valid_q;
    assign bus.req_index   = index_q;
    assign bus.req_channel = channel_q;
    assign bus.req_tick    = req_tick_q;
    assign bus.rsp_ready   = rsp_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_reset   = out_reset_q;
    assign bus.out_red     = red_q;
    assign bus.out_green   = green_q;
    assign bus.out_blue    = blue_q;
    assign frame_tick      = frame_tick_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Bench for pixel_sequencer: a 4x1 instance (cycle table, enable drop,
// colour capture, mid-frame reset) and a 2x3 instance (ordering, latch
// stall, random backpressure with scoreboard).
module tb_pixel_sequencer;
    import pixel_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    pixel_sequencer_if #(.IDX_W(10), .CH_W(3), .CHANNELS(1)) a_if ();
    pixel_sequencer_if #(.IDX_W(10), .CH_W(3), .CHANNELS(3)) b_if ();

    logic        resetn_a = 1'b0, enable_a = 1'b0, frame_tick_a;
    logic        resetn_b = 1'b0, enable_b = 1'b0, frame_tick_b;
    logic [15:0] frame_count_a, frame_count_b;
    logic        ovr_a = 1'b0;
`ifdef PIXEL_SEQUENCER_BRIGHTNESS_EN
    logic [7:0]  brightness_a = 8'd255, brightness_b = 8'd255;
`endif

    pixel_sequencer #(.LED_COUNT(4), .CHANNELS(1), .IDX_W(10), .CH_W(3)) dut_a (
        .clk(clk), .resetn(resetn_a), .enable(enable_a),
`ifdef PIXEL_SEQUENCER_BRIGHTNESS_EN
        .brightness(brightness_a),
`endif
        .bus(a_if), .frame_tick(frame_tick_a), .frame_count(frame_count_a)
    );

    pixel_sequencer #(.LED_COUNT(2), .CHANNELS(3), .IDX_W(10), .CH_W(3)) dut_b (
        .clk(clk), .resetn(resetn_b), .enable(enable_b),
`ifdef PIXEL_SEQUENCER_BRIGHTNESS_EN
        .brightness(brightness_b),
`endif
        .bus(b_if), .frame_tick(frame_tick_b), .frame_count(frame_count_b)
    );

    // Renderer colour as a function of pixel position
    function automatic logic [23:0] colf(input logic [9:0] i, input logic [2:0] c);
        logic [7:0] r;
        r = {i[3:0], 1'b0, c} + 8'h11;
        return {r, r ^ 8'hFF, r ^ 8'h5A};
    endfunction

    // Renderer models: remember the last accepted request, answer with its colour
    logic [9:0]  a_ridx = '0, b_ridx = '0;
    logic [2:0]  a_rch = '0, b_rch = '0;
    logic [23:0] a_col, b_col;
    always @(posedge clk) begin
        if (a_if.req_valid && a_if.req_ready) begin a_ridx <= a_if.req_index; a_rch <= a_if.req_channel; end
        if (b_if.req_valid && b_if.req_ready) begin b_ridx <= b_if.req_index; b_rch <= b_if.req_channel; end
    end
    assign a_col = ovr_a ? 24'hC8FF01 : colf(a_ridx, a_rch);
    assign b_col = colf(b_ridx, b_rch);
    assign a_if.rsp_red = a_col[23:16];
    assign a_if.rsp_green = a_col[15:8];
    assign a_if.rsp_blue = a_col[7:0];
    assign b_if.rsp_red = b_col[23:16];
    assign b_if.rsp_green = b_col[15:8];
    assign b_if.rsp_blue = b_col[7:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Step up to lim negedges until the selected event is seen
    task automatic wait_ev(input int sel, input int lim, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < lim && !hit; n++) begin
            @(negedge clk);
            case (sel)
                0: hit = frame_tick_a;
                1: hit = (a_if.out_valid != '0);
                2: hit = a_if.req_valid && (a_if.req_index == 10'd2);
                3: hit = b_if.req_valid;
                4: hit = (b_if.out_valid != '0);
                5: hit = b_if.out_reset;
                default: hit = 1'b0;
            endcase
        end
        chk({name, "_seen"}, 32'(hit), 32'd1);
    endtask

    typedef struct {
        logic       rv;
        int         idx;
        logic       tick;
        logic       rr;
        logic       ov;
        logic       orst;
        logic       ft;
        int         fc;
        logic [7:0] red;
    } vec_t;
    vec_t tab[16];

    int          e_idx[6] = '{0, 0, 0, 1, 1, 1};
    int          e_ch[6]  = '{0, 1, 2, 0, 1, 2};
    int          e_ov[6]  = '{1, 2, 4, 1, 2, 4};
    int          cnt, pushes, eidx, ech;
    bit          seen, p_req_stall, p_out_stall, push;
    logic [12:0] p_req;
    logic [26:0] p_out;
    logic [23:0] exp_col;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           rv idx tick rr ov rst ft fc red
        tab[0]  = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00};
        tab[1]  = '{1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00};
        tab[2]  = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00};
        tab[3]  = '{1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h11};
        tab[4]  = '{1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h11};
        tab[5]  = '{1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h11};
        tab[6]  = '{1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h21};
        tab[7]  = '{1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h21};
        tab[8]  = '{1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h21};
        tab[9]  = '{1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h31};
        tab[10] = '{1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h31};
        tab[11] = '{1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h31};
        tab[12] = '{1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h41};
        tab[13] = '{1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'h41};
        tab[14] = '{1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h41};
        tab[15] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h41};

        a_if.req_ready = 1'b1; a_if.rsp_valid = 1'b1; a_if.out_ready = 1'b1;
        b_if.req_ready = 1'b1; b_if.rsp_valid = 1'b1; b_if.out_ready = 3'b111;

        // Reset state, sampled the cycle after release
        repeat (3) @(posedge clk);
        #1 resetn_a = 1'b1; resetn_b = 1'b1;
        @(negedge clk);
        chk("rst_a_outs", {a_if.req_valid, a_if.rsp_ready, a_if.out_valid, a_if.out_reset, frame_tick_a, a_if.req_tick}, 0);
        chk("rst_a_cnt_col", {frame_count_a, a_if.out_red, a_if.out_green}, 0);
        chk("rst_b_outs", {b_if.req_valid, b_if.rsp_ready, b_if.out_valid, b_if.out_reset, frame_tick_b}, 0);

        // Zero-wait 4x1 frame, cycle by cycle
        @(posedge clk);
        #1 enable_a = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("c%0d_req_valid", k), 32'(a_if.req_valid), 32'(tab[k].rv));
            chk($sformatf("c%0d_req_index", k), 32'(a_if.req_index), tab[k].idx);
            chk($sformatf("c%0d_req_tick", k), 32'(a_if.req_tick), 32'(tab[k].tick));
            chk($sformatf("c%0d_rsp_ready", k), 32'(a_if.rsp_ready), 32'(tab[k].rr));
            chk($sformatf("c%0d_out_valid", k), 32'(a_if.out_valid), 32'(tab[k].ov));
            chk($sformatf("c%0d_out_reset", k), 32'(a_if.out_reset), 32'(tab[k].orst));
            chk($sformatf("c%0d_frame_tick", k), 32'(frame_tick_a), 32'(tab[k].ft));
            chk($sformatf("c%0d_frame_count", k), 32'(frame_count_a), tab[k].fc);
            chk($sformatf("c%0d_out_red", k), 32'(a_if.out_red), 32'(tab[k].red));
        end

        // Enable dropped mid-frame: frame still completes, then idle
        enable_a = 1'b0;
        wait_ev(0, 40, "disable_frame_end");
        chk("disable_frame_count", 32'(frame_count_a), 32'd2);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_if.req_valid || a_if.out_valid != '0) seen = 1'b1;
        end
        chk("disable_idle", 32'(seen), 32'd0);

        // Colour capture path (scaled in the brightness build)
        ovr_a = 1'b1;
`ifdef PIXEL_SEQUENCER_BRIGHTNESS_EN
        brightness_a = 8'd127;
        exp_col = {8'd100, 8'd127, 8'd0};
`else
        exp_col = {8'd200, 8'd255, 8'd1};
`endif
        enable_a = 1'b1;
        wait_ev(1, 10, "capture_push");
        chk("capture_rgb", {a_if.out_red, a_if.out_green, a_if.out_blue}, exp_col);

        // Reset at pixel 2: valids drop next cycle, restart at index 0
        wait_ev(2, 20, "reset_at_pixel2");
        resetn_a = 1'b0;
        @(negedge clk);
        chk("midrst_valids", {a_if.req_valid, a_if.rsp_ready, a_if.out_valid, a_if.out_reset}, 0);
        chk("midrst_frame_count", 32'(frame_count_a), 32'd0);
        @(posedge clk);
        #1 resetn_a = 1'b1;
        @(negedge clk);
        chk("release_idle", 32'(a_if.req_valid), 32'd0);
        @(negedge clk);
        chk("restart_req", {a_if.req_valid, a_if.req_tick, a_if.req_index}, {1'b1, 1'b1, 10'd0});
        enable_a = 1'b0;

        // 2x3 ordering: pixel-major, channel-minor, one-hot strobes
        enable_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ev(3, 10, $sformatf("ord%0d_req", k));
            chk($sformatf("ord%0d_pos", k), {b_if.req_index, b_if.req_channel}, {10'(e_idx[k]), 3'(e_ch[k])});
            chk($sformatf("ord%0d_tick", k), 32'(b_if.req_tick), (k == 0) ? 32'd1 : 32'd0);
            wait_ev(4, 10, $sformatf("ord%0d_push", k));
            chk($sformatf("ord%0d_onehot", k), 32'(b_if.out_valid), e_ov[k]);
            exp_col = colf(10'(e_idx[k]), 3'(e_ch[k]));
            chk($sformatf("ord%0d_red", k), 32'(b_if.out_red), 32'(exp_col[23:16]));
        end

        // Latch held off by one strip for 5 cycles
        wait_ev(5, 10, "latch_enter");
        chk("latch_all_valid", 32'(b_if.out_valid), 32'd7);
        b_if.out_ready = 3'b101;
        enable_b = 1'b0;
        cnt = 1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (b_if.out_reset) cnt++;
            if (frame_tick_b) seen = 1'b1;
        end
        b_if.out_ready = 3'b111;
        chk("latch_hold_cycles", cnt, 32'd5);
        chk("latch_no_early_tick", 32'(seen), 32'd0);
        @(negedge clk);
        chk("latch_release", {frame_tick_b, b_if.out_reset, b_if.out_valid}, {1'b1, 1'b0, 3'b000});
        chk("latch_frame_count", 32'(frame_count_b), 32'd1);
        @(negedge clk);
        chk("tick_single_cycle", 32'(frame_tick_b), 32'd0);

        // Random backpressure on all handshakes over two frames
        enable_b = 1'b1;
        eidx = 0; ech = 0; pushes = 0;
        p_req_stall = 1'b0; p_out_stall = 1'b0;
        for (int n = 0; n < 3000 && frame_count_b != 16'd3; n++) begin
            @(negedge clk);
            if (p_req_stall)
                chk("req_hold", {b_if.req_valid, b_if.req_index, b_if.req_channel}, {1'b1, p_req[12:0]});
            if (p_out_stall)
                chk("col_hold", {b_if.out_valid, b_if.out_red, b_if.out_green, b_if.out_blue}, p_out);
            b_if.req_ready = 1'($urandom_range(0, 1));
            b_if.rsp_valid = 1'($urandom_range(0, 1));
            b_if.out_ready = 3'($urandom_range(0, 7));
            p_req_stall = b_if.req_valid && !b_if.req_ready;
            p_req = {b_if.req_index, b_if.req_channel};
            push = (b_if.out_valid != '0) && !b_if.out_reset && ((b_if.out_valid & b_if.out_ready) != '0);
            p_out_stall = (b_if.out_valid != '0) && !push && !(b_if.out_reset && (&b_if.out_ready));
            p_out = {b_if.out_valid, b_if.out_red, b_if.out_green, b_if.out_blue};
            if (push) begin
                chk("sb_strobe", 32'(b_if.out_valid), 32'(3'b001 << ech));
                chk("sb_colour", {b_if.out_red, b_if.out_green, b_if.out_blue}, colf(10'(eidx), 3'(ech)));
                pushes++;
                if (ech < 2) ech++;
                else begin ech = 0; eidx = (eidx < 1) ? eidx + 1 : 0; end
            end
        end
        chk("sb_frames", 32'(frame_count_b), 32'd3);
        chk("sb_push_total", pushes, 32'd12);
        enable_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_sequencer.md
# pixel_sequencer

Frame sequencer sitting between the pixel renderer and one or more `pixel_driver` strips. It walks every LED index of every channel, requests a colour from the renderer over a valid/ready handshake, and forwards it to the driver for that channel. At frame end it issues the latch/reset to all drivers and pulses a frame tick. It generalises the single-strip index counter to `CHANNELS` strips of `LED_COUNT` pixels, with true backpressure on both sides and an enable/pause control.

## Interface
- `LED_COUNT`, 298, pixels per channel (≥1)
- `CHANNELS`, 1, number of driver strips (1..8)
- `IDX_W`, 10, index width; requires `LED_COUNT ≤ 2^IDX_W − 1`
- `CH_W`, 3, channel field width; requires `CHANNELS ≤ 2^CH_W`
- `clk` in 1 system clock
- `resetn` in 1 synchronous, active-low reset
- `enable` in 1 start/continue frames
- `req_valid` out 1 pixel request to renderer
- `req_ready` in 1 renderer accepts request
- `req_index` out IDX_W pixel index of request
- `req_channel` out CH_W channel of request
- `req_tick` out 1 high with the first request of each frame (index 0, channel 0)
- `rsp_valid` in 1 renderer colour valid
- `rsp_ready` out 1 sequencer accepts colour
- `rsp_red`/`rsp_green`/`rsp_blue` in 8 each, renderer colour
- `out_valid` out CHANNELS per-driver valid
- `out_ready` in CHANNELS per-driver ready
- `out_reset` out 1 latch command, shared by all drivers
- `out_red`/`out_green`/`out_blue` out 8 each, shared colour bus
- `frame_tick` out 1 one-cycle pulse per completed frame
- `frame_count` out 16 completed frames, wraps at 65535→0

## Operation
- States: IDLE, REQ, WAIT, PUSH, LATCH.
- IDLE: index=0, channel=0. Go to REQ when `enable`=1.
- REQ: `req_valid`=1. On `req_valid && req_ready`, go to WAIT.
- WAIT: `rsp_ready`=1. On `rsp_valid`, capture RGB (post-scaling if enabled) into the output register and go to PUSH.
- PUSH: `out_valid[channel]`=1 and all other bits 0. On `out_ready[channel]`, advance:
  - If channel < CHANNELS−1: channel+1, go to REQ.
  - Otherwise, if index < LED_COUNT−1: channel=0, index+1, go to REQ.
  - Otherwise, go to LATCH.
- LATCH: `out_reset`=1 and `out_valid`=all ones. Wait until `&out_ready`, then:
  - Pulse `frame_tick`.
  - Increment `frame_count`.
  - Set index=0, channel=0.
  - Go to REQ if `enable`=1, otherwise IDLE.
- Ordering: pixel-major, channel-minor (i0c0, i0c1, …, i1c0, …).
- `req_index`/`req_channel` hold steady while `req_valid`=1.
- `out_*` colour holds steady while any `out_valid` bit is 1.
- `enable` deassert mid-frame: the frame completes, including LATCH, then the block idles. It never stops with a partial frame.
- `rsp_valid` outside WAIT is ignored (`rsp_ready`=0).

## Timing
- Reset values while `resetn`=0 and on the following cycle:
  - State IDLE.
  - `req_valid`, `rsp_ready`, `out_valid`, `out_reset`, `frame_tick`, `req_tick` = 0.
  - Colour outputs 0, `frame_count`=0, index/channel 0.
- Reset mid-frame aborts immediately and drops all valids the next cycle. Drivers see no latch.
- With zero-wait handshakes, each pixel takes 3 cycles (REQ, WAIT, PUSH). The latch takes 1 cycle.
- Minimum frame length is 3·LED_COUNT·CHANNELS+1 cycles.
- `frame_tick` is registered: high the cycle after the LATCH handshake, for exactly 1 cycle.
- `frame_count` updates in the same cycle as `frame_tick`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Index and channel counters are exact width. Wrap-around never occurs within a frame because LATCH terminates it.

## Configuration
- `PIXEL_SEQUENCER_BRIGHTNESS_EN` defined:
  - Adds port `brightness` (in, 8).
  - Captured colour per component = (c·(brightness+1))>>8, computed within the WAIT capture cycle. Latency is unchanged.
  - brightness=255 is a pass-through; brightness=0 gives c>>8 = 0.
- Undefined: the port is absent and colour passes through unmodified.

## Structure
- Shared package `pixel_seq_pkg`:
  - State enum (IDLE, REQ, WAIT, PUSH, LATCH).
  - `FRAME_CNT_W`=16.
  - Default `LED_COUNT`/`CHANNELS` constants.
- One sub-module `rgb_scale`: combinational 8×8 multiply-and-shift for the three components. Instantiated only under the macro.

## Test plan
- LED_COUNT=4, CHANNELS=1, all readies tied 1:
  - Request sequence indices 0,1,2,3.
  - `out_reset` high on cycle 13.
  - `frame_tick` on cycle 14.
  - `frame_count`=1.
- CHANNELS=3, LED_COUNT=2 → request order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). `out_valid` one-hot 001,010,100,001,010,100, then 111 with `out_reset`.
- Random stalls on `req_ready`, `rsp_valid`, `out_ready` → request and colour held stable during stalls. No pixel is lost or duplicated (scoreboard colour = f(index,channel)).
- LATCH with `out_ready`=0b101 for 5 cycles, then 0b111 → `out_reset` held for 5 cycles, then `frame_tick` pulses once.
- `resetn` low at pixel 2 → all valids 0 next cycle and `frame_count`=0. With `enable`=1 after release, the sequence restarts at index 0 with `req_tick`=1.
- Brightness build, brightness=127, rsp RGB=(200,255,1) → out RGB=(100,127,0).
